// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader_pkg                                                            |
// | Shared constants and state encoding for the instruction-memory loader.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CHECK  = 3'd2,
        FINISH = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader_if                                                             |
// | Byte-stream handshake plus instruction-RAM write port of the loader.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface imem_loader_if #(
    parameter int ADDR_W = 5
) ();
    import imem_loader_pkg::*;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_we;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_addr, mem_wdata, mem_we
    );

endinterface
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_byte_packer                                                           |
// | Collects bytes little-endian; flags the byte that completes a word.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  wire               clock,
    input  wire               reset_n,
    input  wire               clear,
    input  wire               byte_valid,
    input  wire  [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [BYTE_IDX_W-1:0] r_idx;
    logic [WORD_W-9:0]     r_lo;

    // The top byte is never stored: the word is presented while it is on the bus.
    assign word_valid = byte_valid && (r_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, r_lo};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
            r_lo  <= '0;
        end else if (clear) begin
            r_idx <= '0;
        end else if (byte_valid) begin
            r_idx <= r_idx + BYTE_IDX_W'(1);
            case (r_idx)
                2'd0:    r_lo[7:0]   <= byte_data;
                2'd1:    r_lo[15:8]  <= byte_data;
                2'd2:    r_lo[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader                                                                |
// | Fills the instruction store from a byte stream, then releases the core.    |
// | Optional trailing checksum word: define IMEM_LOADER_CHECKSUM_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int WORD_COUNT = 32
) (
    input  wire               clock,
    input  wire               reset_n,
    input  wire               start,
    imem_loader_if.slave      bus,
    output logic              busy,
    output logic              done,
    output logic              run,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_in_ready;
    logic              w_restart;
    logic              w_accept;
    logic              w_word_valid;
    logic              w_word_wr;
    logic [WORD_W-1:0] w_word;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic [ADDR_W:0]   r_count;

    // A byte offered alongside start is dropped so the new image begins cleanly.
    assign w_in_ready = (r_state == LOAD) || (r_state == CHECK);
    assign w_restart  = start && (r_state != FINISH);
    assign w_accept   = bus.in_valid && w_in_ready && !start;
    assign w_word_wr  = w_word_valid && (r_state == LOAD);

    imem_byte_packer u_packer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (w_restart),
        .byte_valid (w_accept),
        .byte_data  (bus.in_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (start) begin
                    w_state_nxt = LOAD;
                end else if (w_word_wr && (r_addr == c_LAST_ADDR)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_nxt = CHECK;
`else
                    w_state_nxt = FINISH;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                busy = 1'b1;
                if (start)             w_state_nxt = LOAD;
                else if (w_word_valid) w_state_nxt = FINISH;
            end
`endif
            FINISH: begin
                busy        = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = LOAD;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_count     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            r_mem_we <= w_word_wr;
            if (w_restart) begin
                r_addr  <= '0;
                r_count <= '0;
            end else if (w_word_wr) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_word;
                r_addr      <= r_addr + ADDR_W'(1);
                r_count     <= r_count + (ADDR_W + 1)'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum;
    logic              r_err;

    // The word completed while in CHECK is the checksum, compared against the image sum.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else if (w_restart) begin
            r_sum <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_word_wr) r_sum <= r_sum + w_word;
            if (w_word_valid && (r_state == CHECK)) r_err <= (w_word != r_sum);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign run           = done && !err;
    assign words_loaded  = r_count;
    assign bus.in_ready  = w_in_ready;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imem_loader                                                             |
// | Randomised stimulus for imem_loader against a word-level reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int ADDR_W     = 5;
    localparam int WORD_COUNT = 4;

    logic            clock   = 1'b0;
    logic            reset_n = 1'b0;
    logic            start   = 1'b0;
    logic            busy, done, run, err;
    logic [ADDR_W:0] words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .WORD_COUNT(WORD_COUNT)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .run          (run),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Observed writes, with the number of bytes handed over before each one.
    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];
    int                obs_acc[$];
    int                acc_cnt       = 0;
    int                last_we_cyc   = -10;
    int                done_rise_cyc = -1;
    logic              prev_done     = 1'b0;

    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            obs_addr.push_back(bus.mem_addr);
            obs_data.push_back(bus.mem_wdata);
            obs_acc.push_back(acc_cnt);
            last_we_cyc <= cyc;
        end
        if (bus.in_valid && bus.in_ready && !start) acc_cnt <= acc_cnt + 1;
        if ((done === 1'b1) && !prev_done) done_rise_cyc <= cyc;
        prev_done <= (done === 1'b1);
    end

    // Little-endian byte stream of an image, plus its wrap-around sum when enabled.
    task automatic build_stream(input logic [31:0] w[$], output logic [7:0] b[$]);
        logic [31:0] sum;
        b   = {};
        sum = 32'd0;
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) b.push_back(8'((w[i] >> (8 * k)) & 32'hFF));
            sum = sum + w[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int k = 0; k < 4; k++) b.push_back(8'((sum >> (8 * k)) & 32'hFF));
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input bit gaps, output int cycles, output bit ok);
        int   i;
        logic hs;
        i      = 0;
        cycles = 0;
        ok     = 1'b1;
        while (i < b.size()) begin
            if (cycles > 2000) begin
                ok = 1'b0;
                break;
            end
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = b[i];
            end
            @(negedge clock);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clock); #1;
            cycles++;
            if (hs) i++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock); #1;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s done_timeout actual=0 required=1", tag);
        end
    endtask

    task automatic verify_load(input logic [31:0] w[$], input int base, input int acc0, input string tag);
        int n;
        n = obs_addr.size() - base;
        n_tests++;
        if (n !== WORD_COUNT) begin
            n_fail++;
            $display("FAIL %s write_count actual=%0d required=%0d", tag, n, WORD_COUNT);
        end
        for (int i = 0; i < WORD_COUNT && i < n; i++) begin
            n_tests++;
            if (obs_addr[base + i] !== ADDR_W'(i)) begin
                n_fail++;
                $display("FAIL %s addr[%0d] actual=%0d required=%0d", tag, i, obs_addr[base + i], i);
            end
            n_tests++;
            if (obs_data[base + i] !== w[i]) begin
                n_fail++;
                $display("FAIL %s data[%0d] actual=%h required=%h", tag, i, obs_data[base + i], w[i]);
            end
            n_tests++;
            if ((obs_acc[base + i] - acc0) !== 4 * (i + 1)) begin
                n_fail++;
                $display("FAIL %s bytes_before_we[%0d] actual=%0d required=%0d", tag, i, obs_acc[base + i] - acc0, 4 * (i + 1));
            end
        end
        n_tests++;
        if ({done, run, err, busy, bus.in_ready} !== 5'b11000) begin
            n_fail++;
            $display("FAIL %s done_run_err_busy_ready actual=%b required=11000", tag, {done, run, err, busy, bus.in_ready});
        end
        n_tests++;
        if (words_loaded !== (ADDR_W + 1)'(WORD_COUNT)) begin
            n_fail++;
            $display("FAIL %s words_loaded actual=%0d required=%0d", tag, words_loaded, WORD_COUNT);
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        n_tests++;
        if (done_rise_cyc !== last_we_cyc + 1) begin
            n_fail++;
            $display("FAIL %s done_latency actual=%0d required=%0d", tag, done_rise_cyc - last_we_cyc, 1);
        end
`endif
    endtask

    task automatic full_load(input logic [31:0] w[$], input bit gaps, input string tag);
        logic [7:0] b[$];
        int         base, acc0, cycles;
        bit         ok;
        build_stream(w, b);
        base = obs_addr.size();
        acc0 = acc_cnt;
        pulse_start();
        send_bytes(b, gaps, cycles, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s stream_timeout actual=%0d required=%0d", tag, cycles, b.size());
        end
        if (!gaps) begin
            n_tests++;
            if (cycles !== b.size()) begin
                n_fail++;
                $display("FAIL %s throughput_cycles actual=%0d required=%0d", tag, cycles, b.size());
            end
        end
        wait_done(tag);
        verify_load(w, base, acc0, tag);
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        @(negedge clock);
        n_tests++;
        if ({bus.in_ready, bus.mem_we, busy, done, run, err, words_loaded} !== '0) begin
            n_fail++;
            $display("FAIL reset_held outputs actual=%b required=0", {bus.in_ready, bus.mem_we, busy, done, run, err, words_loaded});
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            n_tests++;
            if ({bus.in_ready, bus.mem_we, busy, done, run, err, words_loaded, bus.mem_addr} !== '0) begin
                n_fail++;
                $display("FAIL idle_no_start cycle=%0d actual=%b required=0", c, {bus.in_ready, bus.mem_we, busy, done, run, err, words_loaded, bus.mem_addr});
            end
        end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        n_tests++;
        if (obs_addr.size() !== 0) begin
            n_fail++;
            $display("FAIL idle_writes actual=%0d required=0", obs_addr.size());
        end
    endtask

    task automatic test_basic_load();
        logic [31:0] w[$];
        w = {32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_8193};
        full_load(w, 1'b0, "basic");
    endtask

    task automatic test_gaps();
        logic [31:0] w[$];
        w = {32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_8193};
        full_load(w, 1'b1, "gaps_fixed");
        for (int r = 0; r < 3; r++) begin
            w = {};
            for (int i = 0; i < WORD_COUNT; i++) w.push_back($urandom);
            full_load(w, 1'b1, $sformatf("gaps_rand%0d", r));
        end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] w[$];
        for (int r = 0; r < 2; r++) begin
            w = {};
            for (int i = 0; i < WORD_COUNT; i++) w.push_back($urandom);
            full_load(w, 1'b0, $sformatf("b2b_rand%0d", r));
        end
    endtask

    task automatic test_restart();
        logic [31:0] w_old[$], w_new[$];
        logic [7:0]  b[$], b6[$];
        int          base, cycles;
        bit          ok;
        for (int i = 0; i < WORD_COUNT; i++) begin
            w_old.push_back($urandom);
            w_new.push_back($urandom);
        end
        build_stream(w_old, b);
        for (int i = 0; i < 6; i++) b6.push_back(b[i]);
        base = obs_addr.size();
        pulse_start();
        send_bytes(b6, 1'b0, cycles, ok);
        @(posedge clock); #1;
        n_tests++;
        if ((obs_addr.size() - base) !== 1 || words_loaded !== (ADDR_W + 1)'(1)) begin
            n_fail++;
            $display("FAIL restart_prefix writes=%0d words_loaded=%0d required=1,1", obs_addr.size() - base, words_loaded);
        end
        pulse_start();
        n_tests++;
        if (words_loaded !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear words_loaded=%0d done=%b required=0,0", words_loaded, done);
        end
        build_stream(w_new, b);
        base = obs_addr.size();
        begin
            int acc0;
            acc0 = acc_cnt;
            send_bytes(b, 1'b0, cycles, ok);
            wait_done("restart");
            verify_load(w_new, base, acc0, "restart");
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w[$];
        logic [7:0]  b[$], part[$];
        int          cycles;
        bit          ok;
        for (int i = 0; i < WORD_COUNT; i++) w.push_back($urandom);
        build_stream(w, b);
        part = {b[0], b[1]};
        pulse_start();
        send_bytes(part, 1'b0, cycles, ok);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.in_ready, bus.mem_we, busy, done, run, err, words_loaded} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_word outputs actual=%b required=0", {bus.in_ready, bus.mem_we, busy, done, run, err, words_loaded});
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        full_load(w, 1'b0, "after_reset");

        part = {b[0], b[1], b[2], b[3]};
        pulse_start();
        send_bytes(part, 1'b0, cycles, ok);
        n_tests++;
        if (bus.mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_we_setup mem_we actual=%b required=1", bus.mem_we);
        end
        #1 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.mem_we, busy, bus.in_ready, words_loaded} !== '0) begin
            n_fail++;
            $display("FAIL reset_async_we actual=%b required=0", {bus.mem_we, busy, bus.in_ready, words_loaded});
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] w[$];
        logic [31:0] cks[2];
        logic [7:0]  b[$];
        int          base, cycles;
        bit          ok;
        w      = {32'd1, 32'd2, 32'd3, 32'd4};
        cks[0] = 32'h0000_000A;
        cks[1] = 32'h0000_000B;
        for (int t = 0; t < 2; t++) begin
            b = {};
            foreach (w[i]) for (int k = 0; k < 4; k++) b.push_back(8'((w[i] >> (8 * k)) & 32'hFF));
            for (int k = 0; k < 4; k++) b.push_back(8'((cks[t] >> (8 * k)) & 32'hFF));
            base = obs_addr.size();
            pulse_start();
            send_bytes(b, 1'b1, cycles, ok);
            wait_done($sformatf("checksum%0d", t));
            n_tests++;
            if ((obs_addr.size() - base) !== WORD_COUNT) begin
                n_fail++;
                $display("FAIL checksum%0d write_count actual=%0d required=%0d", t, obs_addr.size() - base, WORD_COUNT);
            end
            n_tests++;
            if ({done, err, run} !== ((t == 0) ? 3'b101 : 3'b110)) begin
                n_fail++;
                $display("FAIL checksum%0d done_err_run actual=%b required=%b", t, {done, err, run}, (t == 0) ? 3'b101 : 3'b110);
            end
        end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_basic_load();
        test_gaps();
        test_back_to_back_random();
        test_restart();
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
